// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: steps doors and pressure through entry/exit runs,
// loading an external countdown timer per phase and advancing on its done flag.
module airlock_sequencer #(
    parameter int unsigned PRESS_SECS   = 420,
    parameter int unsigned DEPRESS_SECS = 480,
    parameter int unsigned DOOR_SECS    = 300
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_entry_i,
    input  logic       req_exit_i,
    input  logic       timer_done_i,
    output logic       timer_load_o,
    output logic [9:0] timer_seconds_o,
    output logic       inner_door_o,
    output logic       outer_door_o,
    output logic       pump_on_o,
    output logic       vent_on_o,
    output logic       busy_o,
    output logic [2:0] state_code_o
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StDepress   = 3'd1,
        StOuterOpen = 3'd2,
        StPress     = 3'd3,
        StInnerOpen = 3'd4
    } state_e;

    typedef enum logic {DirEntry, DirExit} dir_e;

    localparam logic [9:0] PressT   = 10'(PRESS_SECS);
    localparam logic [9:0] DepressT = 10'(DEPRESS_SECS);
    localparam logic [9:0] DoorT    = 10'(DOOR_SECS);

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic       pend_entry_q, pend_entry_d;
    logic       pend_exit_q, pend_exit_d;
    logic       timer_load_q, timer_load_d;
    logic [9:0] timer_seconds_q, timer_seconds_d;
    logic       inner_q, inner_d, outer_q, outer_d;
    logic       pump_q, pump_d, vent_q, vent_d;
    logic       busy_q, busy_d;
    logic       in_idle;
    logic       phase_done;

    assign in_idle = (state_q == StIdle);
    // The load cycle still sees the previous phase's zero count, so done is ignored there.
    assign phase_done = timer_done_i & ~timer_load_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        // A request for the run already in progress is absorbed rather than queued.
        pend_entry_d = pend_entry_q | (req_entry_i & ~(~in_idle & (dir_q == DirEntry)));
        pend_exit_d  = pend_exit_q | (req_exit_i & ~(~in_idle & (dir_q == DirExit)));

        unique case (state_q)
            StIdle: begin
                if (pend_exit_q || req_exit_i) begin
                    state_d     = StInnerOpen;
                    dir_d       = DirExit;
                    pend_exit_d = 1'b0;
                end else if (pend_entry_q || req_entry_i) begin
                    state_d      = StDepress;
                    dir_d        = DirEntry;
                    pend_entry_d = 1'b0;
                end
            end
            StDepress: begin
                if (phase_done) state_d = StOuterOpen;
            end
            StOuterOpen: begin
                if (phase_done) state_d = StPress;
            end
            StPress: begin
                if (phase_done) state_d = (dir_q == DirEntry) ? StInnerOpen : StIdle;
            end
            StInnerOpen: begin
                if (phase_done) state_d = (dir_q == DirEntry) ? StIdle : StDepress;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_load_d    = (state_d != state_q) && (state_d != StIdle);
        timer_seconds_d = timer_seconds_q;
        if (timer_load_d) begin
            case (state_d)
                StDepress: timer_seconds_d = DepressT;
                StPress:   timer_seconds_d = PressT;
                default:   timer_seconds_d = DoorT;
            endcase
        end
        inner_d = (state_d == StInnerOpen);
        outer_d = (state_d == StOuterOpen);
        pump_d  = (state_d == StPress);
        vent_d  = (state_d == StDepress);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            dir_q           <= DirEntry;
            pend_entry_q    <= 1'b0;
            pend_exit_q     <= 1'b0;
            timer_load_q    <= 1'b0;
            timer_seconds_q <= '0;
            inner_q         <= 1'b0;
            outer_q         <= 1'b0;
            pump_q          <= 1'b0;
            vent_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            pend_entry_q    <= pend_entry_d;
            pend_exit_q     <= pend_exit_d;
            timer_load_q    <= timer_load_d;
            timer_seconds_q <= timer_seconds_d;
            inner_q         <= inner_d;
            outer_q         <= outer_d;
            pump_q          <= pump_d;
            vent_q          <= vent_d;
            busy_q          <= busy_d;
        end
    end

    assign timer_load_o    = timer_load_q;
    assign timer_seconds_o = timer_seconds_q;
    assign inner_door_o    = inner_q;
    assign outer_door_o    = outer_q;
    assign pump_on_o       = pump_q;
    assign vent_on_o       = vent_q;
    assign busy_o          = busy_q;
    assign state_code_o    = state_q;

endmodule
